writeback_queue: RTL and testbench

Buffered writer for the register file's single write port. It accepts results from execute and memory stages over a valid/ready handshake and holds them in an in-order FIFO. It drains one entry per cycle onto the register file's write port. It also reports read-after-write hazards for the two register-file read addresses, so decode can stall while a pending write to the same register is still queued.

---
 rtl/writeback_queue.sv | 106 ++++++++++
 tb/tb_writeback_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// In-order write-back FIFO feeding the register file's single write port,
// with read-after-write hazard reporting for the two decode read addresses.

package wbq_defs_pkg;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;
endpackage

module writeback_queue
  import wbq_defs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    _CLK,
  input  logic                    _RST_N,
  input  logic                    _resValid,
  input  logic [REG_WIDTH-1:0]    _resDest,
  input  logic [DATA_WIDTH-1:0]   _resVal,
  output logic                    resReady,
  input  logic                    _wbHold,
  input  logic                    _flush,
  input  logic [REG_WIDTH-1:0]    _lookupA,
  input  logic [REG_WIDTH-1:0]    _lookupB,
  output logic                    hazardA,
  output logic                    hazardB,
  output logic                    regWrite,
  output logic [REG_WIDTH-1:0]    regDest,
  output logic [DATA_WIDTH-1:0]   writeVal,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_WIDTH-1:0]  destMem [DEPTH];
  logic [DATA_WIDTH-1:0] valMem  [DEPTH];
  logic [DEPTH-1:0]      entryVld;
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic                  enq;
  logic                  deq;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign resReady = !full;
  assign enq      = _resValid && resReady;
  assign deq      = regWrite;

  // Outputs are forced to zero when not writing so the register file never sees stale data.
  always_comb begin
    regWrite = !empty && !_wbHold;
    regDest  = '0;
    writeVal = '0;
    if (regWrite) begin
      regDest  = destMem[rdPtr];
      writeVal = valMem[rdPtr];
    end
  end

  // The head still counts while it is being written; valid bits gate out stale storage.
  always_comb begin
    hazardA = 1'b0;
    hazardB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryVld[i] && (destMem[i] == _lookupA)) hazardA = 1'b1;
      if (entryVld[i] && (destMem[i] == _lookupB)) hazardB = 1'b1;
    end
  end

  always_ff @(posedge _CLK or negedge _RST_N) begin
    if (!_RST_N) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      entryVld <= '0;
    end else if (_flush) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      entryVld <= '0;
    end else begin
      // Enqueue and dequeue never target the same slot: that needs empty or full.
      if (enq) begin
        entryVld[wrPtr] <= 1'b1;
        wrPtr           <= wrPtr + PTR_W'(1);
      end
      if (deq) begin
        entryVld[rdPtr] <= 1'b0;
        rdPtr           <= rdPtr + PTR_W'(1);
      end
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (deq && !enq) count <= count - CNT_W'(1);
    end
  end

  // Payload storage carries no reset; entryVld decides what is meaningful.
  always_ff @(posedge _CLK) begin
    if (enq) begin
      destMem[wrPtr] <= _resDest;
      valMem[wrPtr]  <= _resVal;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: expected writes are queued at issue time
// and a negedge monitor pops and compares every register-file write.

module tb_writeback_queue;
  import wbq_defs_pkg::*;

  localparam int DEPTH = 4;

  logic                   _CLK = 1'b0;
  logic                   _RST_N;
  logic                   _resValid;
  logic [REG_WIDTH-1:0]   _resDest;
  logic [DATA_WIDTH-1:0]  _resVal;
  logic                   resReady;
  logic                   _wbHold;
  logic                   _flush;
  logic [REG_WIDTH-1:0]   _lookupA;
  logic [REG_WIDTH-1:0]   _lookupB;
  logic                   hazardA;
  logic                   hazardB;
  logic                   regWrite;
  logic [REG_WIDTH-1:0]   regDest;
  logic [DATA_WIDTH-1:0]  writeVal;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   full;

  int total = 0;
  int bad   = 0;

  logic [REG_WIDTH+DATA_WIDTH-1:0] expQ [$];
  logic [REG_WIDTH+DATA_WIDTH-1:0] expE;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    ._CLK      (_CLK),
    ._RST_N    (_RST_N),
    ._resValid (_resValid),
    ._resDest  (_resDest),
    ._resVal   (_resVal),
    .resReady  (resReady),
    ._wbHold   (_wbHold),
    ._flush    (_flush),
    ._lookupA  (_lookupA),
    ._lookupB  (_lookupB),
    .hazardA   (hazardA),
    .hazardB   (hazardB),
    .regWrite  (regWrite),
    .regDest   (regDest),
    .writeVal  (writeVal),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 _CLK = ~_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge _CLK);
    #1;
  endtask

  task automatic offer(input int d, input int v);
    _resValid = 1'b1;
    _resDest  = REG_WIDTH'(d);
    _resVal   = DATA_WIDTH'(v);
  endtask

  task automatic expectWr(input int d, input int v);
    expQ.push_back({REG_WIDTH'(d), DATA_WIDTH'(v)});
  endtask

  // Scoreboard monitor
  always @(negedge _CLK) begin
    if (_RST_N === 1'b1 && regWrite === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected write: dest %0d val %0d, expected no write", regDest, writeVal);
      end else begin
        expE = expQ.pop_front();
        chk("wr dest", 32'(regDest), 32'(expE[REG_WIDTH+DATA_WIDTH-1:DATA_WIDTH]));
        chk("wr val", writeVal, expE[DATA_WIDTH-1:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    _RST_N = 1'b0; _resValid = 1'b0; _resDest = '0; _resVal = '0;
    _wbHold = 1'b0; _flush = 1'b0; _lookupA = '0; _lookupB = '0;

    // Reset state
    repeat (2) @(posedge _CLK);
    #1;
    chk("rst regWrite", 32'(regWrite), 0);
    chk("rst regDest", 32'(regDest), 0);
    chk("rst writeVal", writeVal, 0);
    chk("rst hazardA", 32'(hazardA), 0);
    chk("rst hazardB", 32'(hazardB), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst count", 32'(count), 0);
    chk("rst resReady", 32'(resReady), 1);
    _RST_N = 1'b1;
    cyc();

    // Single result
    _lookupA = 5'd2;
    offer(2, 7); expectWr(2, 7);
    @(negedge _CLK);
    chk("t1 hazard before enq", 32'(hazardA), 0);
    cyc();
    _resValid = 1'b0;
    @(negedge _CLK);
    chk("t1 regWrite", 32'(regWrite), 1);
    chk("t1 hazardA", 32'(hazardA), 1);
    chk("t1 count", 32'(count), 1);
    cyc();
    @(negedge _CLK);
    chk("t1 regWrite after", 32'(regWrite), 0);
    chk("t1 count after", 32'(count), 0);
    chk("t1 hazardA after", 32'(hazardA), 0);
    cyc();

    // Fill under hold
    _wbHold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(i, 10 + i); expectWr(i, 10 + i);
      cyc();
    end
    offer(5, 55);
    @(negedge _CLK);
    chk("t2 count full", 32'(count), 4);
    chk("t2 full", 32'(full), 1);
    chk("t2 resReady", 32'(resReady), 0);
    chk("t2 held regWrite", 32'(regWrite), 0);
    chk("t2 held regDest", 32'(regDest), 0);
    chk("t2 held writeVal", writeVal, 0);
    cyc();
    @(negedge _CLK);
    chk("t2 fifth refused", 32'(count), 4);
    cyc();
    _wbHold = 1'b0;
    expectWr(5, 55);
    @(negedge _CLK);
    chk("t2 drain0 regWrite", 32'(regWrite), 1);
    chk("t2 drain0 resReady", 32'(resReady), 0);
    cyc();
    @(negedge _CLK);
    chk("t2 full+deq count", 32'(count), 3);
    chk("t2 resReady rises", 32'(resReady), 1);
    cyc();
    _resValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge _CLK);
      chk("t2 drain no bubble", 32'(regWrite), 1);
      cyc();
    end
    @(negedge _CLK);
    chk("t2 drained", 32'(count), 0);
    cyc();

    // Same destination twice
    _lookupA = 5'd2;
    offer(2, 11); expectWr(2, 11);
    cyc();
    offer(2, 55); expectWr(2, 55);
    @(negedge _CLK);
    chk("t3 hazard first", 32'(hazardA), 1);
    cyc();
    _resValid = 1'b0;
    @(negedge _CLK);
    chk("t3 hazard second", 32'(hazardA), 1);
    chk("t3 count", 32'(count), 1);
    cyc();
    @(negedge _CLK);
    chk("t3 hazard cleared", 32'(hazardA), 0);
    cyc();

    // Wrap-around stream
    for (int k = 0; k < 10; k++) begin
      offer(10 + k, 100 + k); expectWr(10 + k, 100 + k);
      if (k > 0) begin
        @(negedge _CLK);
        chk("t4 stream count", 32'(count), 1);
        chk("t4 stream regWrite", 32'(regWrite), 1);
      end
      cyc();
    end
    _resValid = 1'b0;
    @(negedge _CLK);
    chk("t4 tail count", 32'(count), 1);
    cyc();
    @(negedge _CLK);
    chk("t4 end count", 32'(count), 0);
    cyc();

    // Flush with concurrent enqueue
    _wbHold = 1'b1;
    _lookupA = 5'd6;
    _lookupB = 5'd4;
    for (int i = 0; i < 3; i++) begin
      offer(6 + i, 60 + i);
      cyc();
    end
    _flush = 1'b1;
    offer(4, 14);
    @(negedge _CLK);
    chk("t5 pre-flush count", 32'(count), 3);
    chk("t5 pre-flush hazardA", 32'(hazardA), 1);
    cyc();
    _flush = 1'b0;
    _resValid = 1'b0;
    @(negedge _CLK);
    chk("t5 count", 32'(count), 0);
    chk("t5 empty", 32'(empty), 1);
    chk("t5 hazardA", 32'(hazardA), 0);
    chk("t5 hazardB", 32'(hazardB), 0);
    cyc();
    _wbHold = 1'b0;

    // Async reset mid-drain
    _wbHold = 1'b1;
    _lookupA = 5'd9;
    _lookupB = 5'd10;
    offer(9, 90);
    cyc();
    offer(10, 100);
    cyc();
    _resValid = 1'b0;
    _wbHold = 1'b0;
    expectWr(9, 90);
    @(negedge _CLK);
    chk("t6 count before rst", 32'(count), 2);
    chk("t6 hazardB before rst", 32'(hazardB), 1);
    #1;
    _RST_N = 1'b0;
    #1;
    chk("t6 rst regWrite", 32'(regWrite), 0);
    chk("t6 rst count", 32'(count), 0);
    chk("t6 rst hazardA", 32'(hazardA), 0);
    chk("t6 rst hazardB", 32'(hazardB), 0);
    chk("t6 rst empty", 32'(empty), 1);
    cyc();
    _RST_N = 1'b1;
    cyc();
    offer(3, 33); expectWr(3, 33);
    cyc();
    _resValid = 1'b0;
    @(negedge _CLK);
    chk("t6 post count", 32'(count), 1);
    chk("t6 post regWrite", 32'(regWrite), 1);
    cyc();
    @(negedge _CLK);
    chk("t6 post drained", 32'(count), 0);
    cyc();

    repeat (2) cyc();
    chk("leftover expected writes", 32'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
